pub_key_stream: RTL and testbench

PUB_KEY_STREAM -- requirements
Module: pub_key_stream

---
 rtl/pub_key_stream.sv | 164 ++++++++++++++++
 tb/tb_pub_key_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pub_key_stream.sv
// pub_key_stream
//   Streams keys through a two-stage modular transform into a small result
//   FIFO. Forward mode maps sk -> pk = (sk + Q_OFF) mod P_MOD; inverse mode
//   maps pk -> sk = (pk - Q_OFF) mod P_MOD. Keys outside 1..P_MOD-1 are
//   still carried through, with key_out forced to 0 and out_err set.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   mode        01 forward, 10 inverse, 00/11 idle (no accepts)
//   in_valid    key_in is presented
//   key_in      key operand, W bits
//   in_ready    key_in is accepted this cycle when in_valid is also 1
//   out_valid   FIFO head is valid
//   out_ready   consumer takes the FIFO head
//   key_out     result at the FIFO head (0 when empty)
//   out_err     head entry came from an invalid key (0 when empty)
//   fifo_count  number of entries held in the FIFO
module pub_key_stream #(
  parameter int W     = 8,
  parameter int P_MOD = 227,
  parameter int Q_OFF = 225,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  input  logic [W-1:0]               key_in,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               key_out,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [W:0]  P_W     = (W+1)'(P_MOD);
  localparam logic [W:0]  Q_W     = (W+1)'(Q_OFF);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // stage 1: captured operand, mode and validity
  logic         s1_valid;
  logic         s1_fwd;
  logic         s1_ok;
  logic [W-1:0] s1_key;

  // stage 2: computed result waiting to be written into the FIFO
  logic         s2_valid;
  logic         s2_err;
  logic [W-1:0] s2_key;

  // FIFO storage and pointers
  logic [W-1:0]  mem_key [DEPTH];
  logic          mem_err [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          mode_ok;
  logic          key_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  logic [W:0]    k_ext;
  logic [W:0]    fwd_sum;
  logic [W:0]    fwd_res;
  logic [W:0]    inv_res;
  logic [W:0]    res;

  assign mode_ok = (mode == 2'b01) || (mode == 2'b10);
  assign key_ok  = (key_in != '0) && ({1'b0, key_in} < P_W);

  // Entries still in the pipeline reserve FIFO space so a push can never
  // land on a full FIFO. rst_n gates the handshake so nothing is offered
  // while the block is held in reset.
  assign occupancy = {1'b0, count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
  assign in_ready  = rst_n && mode_ok && (occupancy < DEPTH_C);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fwd   <= 1'b0;
      s1_ok    <= 1'b0;
      s1_key   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_key <= key_in;
        s1_fwd <= (mode == 2'b01);
        s1_ok  <= key_ok;
      end
    end
  end

  // Operands are below P_MOD whenever the result is used, so a single
  // conditional subtraction (forward) or addition (inverse) is enough.
  always_comb begin
    k_ext   = {1'b0, s1_key};
    fwd_sum = k_ext + Q_W;
    fwd_res = (fwd_sum >= P_W) ? (fwd_sum - P_W) : fwd_sum;
    inv_res = (k_ext >= Q_W) ? (k_ext - Q_W) : (k_ext + P_W - Q_W);
    res     = '0;
    if (s1_ok) begin
      res = s1_fwd ? fwd_res : inv_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_key   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_key <= res[W-1:0];
        s2_err <= !s1_ok;
      end
    end
  end

  assign push = s2_valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_key[wr_ptr] <= s2_key;
      mem_err[wr_ptr] <= s2_err;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign key_out    = out_valid ? mem_key[rd_ptr] : '0;
  assign out_err    = out_valid ? mem_err[rd_ptr] : 1'b0;
  assign fifo_count = count;

endmodule

// File: tb/tb_pub_key_stream.sv
// Testbench for pub_key_stream: behavioural queue model of accepted entries,
// each becoming visible two edges after acceptance, compared every cycle.
module tb_pub_key_stream;

  localparam int W = 8;
  localparam int P = 227;
  localparam int Q = 225;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] key_out;
  logic         out_err;
  logic [2:0]   fifo_count;

  pub_key_stream #(.W(W), .P_MOD(P), .Q_OFF(Q), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .key_in(key_in), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .key_out(key_out), .out_err(out_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int key;
    bit err;
    int avail;
  } item_t;

  item_t q[$];
  int    edge_n = 0;
  int    total = 0;
  int    bad = 0;
  int    log_key[$];
  bit    log_err[$];
  bit    dut_rdy_seen;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_res(input bit fwd, input int k, output int r, output bit e);
    if (k < 1 || k > P - 1) begin
      r = 0;
      e = 1'b1;
    end else begin
      e = 1'b0;
      if (fwd) r = (k + Q) % P;
      else     r = (k >= Q) ? k - Q : k + P - Q;
    end
  endfunction

  function automatic int m_count();
    int n = 0;
    foreach (q[i]) if (q[i].avail <= edge_n) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return rst_n && (mode == 2'b01 || mode == 2'b10) && (q.size() < D);
  endfunction

  task automatic step(input logic [1:0] md, input bit v, input int k, input bit ordy);
    bit    acc;
    bit    pop;
    bit    mv;
    int    r;
    bit    e;
    item_t it;
    mode      = md;
    in_valid  = v;
    key_in    = W'(k);
    out_ready = ordy;
    #1;
    mv = (m_count() > 0);
    chk("in_ready", int'(in_ready), int'(m_ready()));
    chk("out_valid", int'(out_valid), int'(mv));
    chk("key_out", int'(key_out), mv ? q[0].key : 0);
    chk("out_err", int'(out_err), mv ? int'(q[0].err) : 0);
    chk("fifo_count", int'(fifo_count), m_count());
    dut_rdy_seen = in_ready;
    acc = v && m_ready();
    pop = mv && ordy;
    if (pop) begin
      log_key.push_back(int'(key_out));
      log_err.push_back(out_err);
    end
    @(posedge clk);
    edge_n++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      model_res(md == 2'b01, k & 8'hFF, r, e);
      it.key = r;
      it.err = e;
      it.avail = edge_n + 2;
      q.push_back(it);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 0, ordy);
  endtask

  task automatic chk_log(input string name, input int exp_k[], input bit exp_e[]);
    chk({name, "_len"}, log_key.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < log_key.size(); i++) begin
      chk({name, "_key"}, log_key[i], exp_k[i]);
      chk({name, "_err"}, int'(log_err[i]), int'(exp_e[i]));
    end
    log_key.delete();
    log_err.delete();
  endtask

  task automatic do_reset();
    mode     = 2'b01;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_key_out", int'(key_out), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    q.delete();
    @(posedge clk);
    edge_n++;
    #1;
    chk("rst_hold_count", int'(fifo_count), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int nacc;
    int idx;
    int guard;
    int bl[8];
    bl = '{0, 1, 2, P - 1, P, 255, Q, Q - 1};

    #2;
    chk("init_fifo_count", int'(fifo_count), 0);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_in_ready", int'(in_ready), 0);
    @(posedge clk); edge_n++;
    @(posedge clk); edge_n++;
    #1;
    rst_n = 1'b1;

    // forward 10, 2, 1 -> 8, 0, 226 with two-edge latency
    log_key.delete(); log_err.delete();
    step(2'b01, 1'b1, 10, 1'b1);
    step(2'b01, 1'b1, 2, 1'b1);
    chk("lat_edge1_valid", int'(out_valid), 0);
    step(2'b01, 1'b1, 1, 1'b1);
    chk("lat_edge2_valid", int'(out_valid), 1);
    chk("lat_edge2_key", int'(key_out), 8);
    idle(5, 1'b1);
    chk_log("fwd", '{8, 0, 226}, '{0, 0, 0});

    // inverse 8, 226 -> 10, 1
    step(2'b10, 1'b1, 8, 1'b1);
    step(2'b10, 1'b1, 226, 1'b1);
    idle(5, 1'b1);
    chk_log("inv", '{10, 1}, '{0, 0});

    // invalid keys interleaved with a valid one
    step(2'b01, 1'b1, 0, 1'b1);
    step(2'b01, 1'b1, 5, 1'b1);
    step(2'b01, 1'b1, 227, 1'b1);
    idle(5, 1'b1);
    chk_log("invalid", '{0, 3, 0}, '{1, 0, 1});

    // backpressure: 6 keys offered, 4 accepted
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(2'b01, 1'b1, 20 + i, 1'b0);
      if (dut_rdy_seen) nacc++;
    end
    chk("bp_accepted", nacc, 4);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 0, 1'b0);
    chk("bp_fifo_count", int'(fifo_count), 4);
    chk("bp_in_ready", int'(in_ready), 0);
    idx = nacc;
    guard = 0;
    while ((idx < 6 || q.size() != 0) && guard < 40) begin
      step(2'b01, idx < 6, 20 + idx, 1'b1);
      if (idx < 6 && dut_rdy_seen) idx++;
      guard++;
    end
    chk("bp_drain_timeout", int'(guard < 40), 1);
    chk_log("bp", '{18, 19, 20, 21, 22, 23}, '{0, 0, 0, 0, 0, 0});

    // mode captured at acceptance; idle mode blocks input
    step(2'b01, 1'b1, 10, 1'b1);
    step(2'b10, 1'b0, 0, 1'b1);
    step(2'b00, 1'b1, 50, 1'b1);
    chk("idle_in_ready", int'(in_ready), 0);
    step(2'b11, 1'b1, 60, 1'b1);
    idle(4, 1'b1);
    chk_log("mode_sw", '{8}, '{0});

    // reset with 3 entries buffered
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 3 + i, 1'b0);
    idle(2, 1'b0);
    chk("pre_rst_count", int'(fifo_count), 3);
    do_reset();
    idle(3, 1'b1);
    log_key.delete(); log_err.delete();

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] md;
      int         sel;
      int         k;
      sel = $urandom_range(0, 9);
      md  = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11;
      k   = ($urandom_range(0, 7) == 0) ? bl[$urandom_range(0, 7)] : $urandom_range(0, 255);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(md, $urandom_range(0, 3) != 0, k, $urandom_range(0, 2) != 0);
    end
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
